// File: rtl/alu_cmp_seq.sv
// alu_cmp_seq -- multi-cycle, slice-serial compare unit for the ALU compare path.
//
// Two WIDTH-bit operands are compared SLICE bits per cycle, starting at the
// most significant slice. The 1-bit outcome is returned zero-extended on S.
//
// Op encoding (matches ALUFun[3:1]):
//   000 NEQ, 001 EQ, 010 LT (signed), 011 LTU (unsigned),
//   110 LEZ, 101 LTZ, 111 GTZ (B is forced to zero for these three),
//   100 reserved (the scan still runs, S = 0).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in/out sides are independent; in_ready is high only in IDLE and
// out_valid only in DONE, so at most one operation is in flight.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   in_valid   A/B/op valid        in_ready   unit idle, can accept
//   A, B       operands            op         compare select
//   out_valid  S holds a result    out_ready  consumer takes the result
//   S          {WIDTH-1 zeros, outcome}
//   dbg_state  current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Optional feature: define CMP_EARLY_EXIT_EN to leave RUN on the edge that
// processes the first differing slice instead of always scanning all slices.
module alu_cmp_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] TOP = CW'(N - 1);

    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_slice
        $error("alu_cmp_seq: WIDTH must be a positive multiple of SLICE");
    end

    localparam logic [2:0] OP_NEQ = 3'b000;
    localparam logic [2:0] OP_EQ  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b010;
    localparam logic [2:0] OP_LTU = 3'b011;
    localparam logic [2:0] OP_LTZ = 3'b101;
    localparam logic [2:0] OP_LEZ = 3'b110;
    localparam logic [2:0] OP_GTZ = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             decided, lt;
    logic [WIDTH-1:0] s_q;

    logic [SLICE-1:0] a_sl, b_sl;
    logic             top_slice, last_slice, signed_op;
    logic             slice_ne, slice_lt;
    logic             decided_nxt, lt_nxt, scan_end;
    logic             eq, outcome;
    logic             accept, zero_op;

    assign in_ready  = (state == ST_IDLE);
    assign dbg_state = state;
    assign S         = s_q;
    assign accept    = in_valid && (state == ST_IDLE);
    assign zero_op   = (op == OP_LEZ) || (op == OP_LTZ) || (op == OP_GTZ);

    // Select the slice addressed by the down-counter.
    if (N == 1) begin : g_one_slice
        assign a_sl = a_q;
        assign b_sl = b_q;
    end else begin : g_many_slices
        logic [N-1:0][SLICE-1:0] a_v, b_v;
        assign a_v  = a_q;
        assign b_v  = b_q;
        assign a_sl = a_v[cnt];
        assign b_sl = b_v[cnt];
    end

    assign top_slice  = (cnt == TOP);
    assign last_slice = (cnt == '0);
    assign signed_op  = (op_q == OP_LT) || (op_q == OP_LEZ) ||
                        (op_q == OP_LTZ) || (op_q == OP_GTZ);

    // Only the top slice carries the sign; lower slices are plain magnitudes.
    assign slice_ne = (a_sl != b_sl);
    assign slice_lt = (top_slice && signed_op) ? ($signed(a_sl) < $signed(b_sl))
                                               : (a_sl < b_sl);

    // The first differing slice decides; after that the flags are frozen.
    assign decided_nxt = decided | slice_ne;
    assign lt_nxt      = decided ? lt : slice_lt;

`ifdef CMP_EARLY_EXIT_EN
    assign scan_end = last_slice || (slice_ne && !decided);
`else
    assign scan_end = last_slice;
`endif

    // Outcome from the flags as they stand after the current slice.
    always_comb begin
        eq      = !decided_nxt;
        outcome = 1'b0;
        case (op_q)
            OP_EQ:                 outcome = eq;
            OP_NEQ:                outcome = !eq;
            OP_LT, OP_LTU, OP_LTZ: outcome = lt_nxt;
            OP_LEZ:                outcome = lt_nxt | eq;
            OP_GTZ:                outcome = !lt_nxt & !eq;
            default:               outcome = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (scan_end)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            cnt       <= '0;
            decided   <= 1'b0;
            lt        <= 1'b0;
            s_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_q     <= A;
                        b_q     <= zero_op ? '0 : B;
                        op_q    <= op;
                        cnt     <= TOP;
                        decided <= 1'b0;
                        lt      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    decided <= decided_nxt;
                    lt      <= lt_nxt;
                    if (!last_slice) begin
                        cnt <= cnt - CW'(1);
                    end
                    if (scan_end) begin
                        s_q       <= WIDTH'(outcome);
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        s_q       <= '0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmp_seq.sv
// Bench for alu_cmp_seq: a driver issues operations, a reference model
// computes the expected outcome and latency from the compare rules, and a
// monitor pops the expectation whenever the DUT presents a result.
// Two extra instances (64/16 and 32/32) cover other parametrisations.
module tb_alu_cmp_seq;

    localparam int W  = 32;
    localparam int SL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  a, b, s;
    logic [2:0]    op;
    logic [1:0]    dbg;

    logic          p_valid, p_ready;
    logic [2:0]    p_op;
    logic          ir1, ov1, ir2, ov2;
    logic [63:0]   a1, b1, s1;
    logic [31:0]   a2, b2, s2;
    logic [1:0]    dbg1, dbg2;

    alu_cmp_seq #(.WIDTH(W), .SLICE(SL)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .S(s), .dbg_state(dbg)
    );

    alu_cmp_seq #(.WIDTH(64), .SLICE(16)) u_w64 (
        .clk(clk), .reset(reset), .in_valid(p_valid), .in_ready(ir1),
        .A(a1), .B(b1), .op(p_op), .out_valid(ov1), .out_ready(p_ready),
        .S(s1), .dbg_state(dbg1)
    );

    alu_cmp_seq #(.WIDTH(32), .SLICE(32)) u_n1 (
        .clk(clk), .reset(reset), .in_valid(p_valid), .in_ready(ir2),
        .A(a2), .B(b2), .op(p_op), .out_valid(ov2), .out_ready(p_ready),
        .S(s2), .dbg_state(dbg2)
    );

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     rdy_mode = 0;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    longint       acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic is_zero_op(input logic [2:0] o);
        return (o == 3'b110) || (o == 3'b101) || (o == 3'b111);
    endfunction

    // Reference outcome: operands are zero-padded w-bit values.
    function automatic logic model_s(input logic [63:0] x, input logic [63:0] y,
                                     input logic [2:0] o, input int w);
        longint sx = longint'(x << (64 - w)) >>> (64 - w);
        longint sy = longint'(y << (64 - w)) >>> (64 - w);
        case (o)
            3'b001:  return x == y;
            3'b000:  return x != y;
            3'b010:  return sx < sy;
            3'b011:  return x < y;
            3'b110:  return sx <= 0;
            3'b101:  return sx < 0;
            3'b111:  return sx > 0;
            default: return 1'b0;
        endcase
    endfunction

    // Reference latency in edges after the accept edge.
    function automatic int model_lat(input logic [63:0] x, input logic [63:0] y,
                                     input logic [2:0] o, input int w, input int sl);
`ifdef CMP_EARLY_EXIT_EN
        logic [63:0] ey = is_zero_op(o) ? 64'd0 : y;
        logic [63:0] m  = (sl == 64) ? '1 : ((64'd1 << sl) - 64'd1);
        for (int j = 1; j <= w / sl; j++) begin
            if (((x >> (w - j * sl)) & m) != ((ey >> (w - j * sl)) & m)) return j;
        end
`endif
        return w / sl;
    endfunction

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] to);
        logic [W-1:0] e;
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready) begin
            // Busy: wiggle inputs to show they are ignored outside IDLE.
            in_valid = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            op = 3'($urandom_range(0, 7));
            waited++;
            if (waited > 100) begin
                check("send_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b1;
        a  = ta;
        b  = tb;
        op = to;
        @(posedge clk);
        #1;
        e = '0;
        e[0] = model_s(64'(ta), 64'(tb), to, W);
        exp_q.push_back(e);
        lat_q.push_back(model_lat(64'(ta), 64'(tb), to, W, SL));
        acc_q.push_back(cyc);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 300) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
    endtask

    // Monitor: one pop per presented result, then S must hold while stalled.
    initial begin
        logic         seen;
        logic [W-1:0] held;
        logic [W-1:0] e;
        int           l;
        longint       ac;
        seen = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result_pending", 64'd0, 64'd1);
                    end else begin
                        e  = exp_q.pop_front();
                        l  = lat_q.pop_front();
                        ac = acc_q.pop_front();
                        check("result_S", 64'(s), 64'(e));
                        check("latency", 64'(cyc - ac), 64'(l));
                    end
                    held = s;
                end else begin
                    check("S_stable", 64'(s), 64'(held));
                end
                seen = !out_ready;
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic run_pair(input logic [63:0] x1, input logic [63:0] y1,
                            input logic [31:0] x2, input logic [31:0] y2, input logic [2:0] o);
        longint ac;
        logic got1, got2;
        int k;
        k = 0;
        @(negedge clk);
        while (!(ir1 && ir2) && k < 50) begin
            @(negedge clk);
            k++;
        end
        p_valid = 1'b1;
        p_op = o;
        a1 = x1; b1 = y1; a2 = x2; b2 = y2;
        @(posedge clk);
        #1;
        ac = cyc;
        p_valid = 1'b0;
        got1 = 1'b0;
        got2 = 1'b0;
        for (int i = 0; i < 20 && !(got1 && got2); i++) begin
            @(negedge clk);
            #1;
            if (ov1 && !got1) begin
                got1 = 1'b1;
                check("w64_S", s1, 64'(model_s(x1, y1, o, 64)));
                check("w64_latency", 64'(cyc - ac), 64'(model_lat(x1, y1, o, 64, 16)));
            end
            if (ov2 && !got2) begin
                got2 = 1'b1;
                check("n1_S", 64'(s2), 64'(model_s(64'(x2), 64'(y2), o, 32)));
                check("n1_latency", 64'(cyc - ac), 64'(model_lat(64'(x2), 64'(y2), o, 32, 32)));
            end
        end
        check("pair_results_seen", 64'({got1, got2}), 64'd3);
    endtask

    function automatic logic [W-1:0] pick_a();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] ra, rb;
        logic         got;
        logic [63:0]  w1;
        reset = 1'b0;
        in_valid = 1'b0;
        a = '0; b = '0; op = '0;
        p_valid = 1'b0; p_ready = 1'b1; p_op = '0;
        a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_S", 64'(s), 64'd0);
        reset = 1'b1;

        // Signed vs unsigned
        send(32'hFFFF_FFFF, 32'h0000_0001, 3'b010);
        send(32'hFFFF_FFFF, 32'h0000_0001, 3'b011);
        // Zero ops (B must be ignored)
        send(32'h0, $urandom, 3'b110);
        send(32'h0, $urandom, 3'b101);
        send(32'h0, $urandom, 3'b111);
        send(32'h8000_0000, $urandom, 3'b101);
        send(32'h0000_0100, $urandom, 3'b111);
        // Early exit and equal operands
        send(32'h1200_0000, 32'h1300_0000, 3'b000);
        send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b001);
        send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b000);
        send(32'h7FFF_FFFF, 32'h8000_0000, 3'b010);
        send(32'h0000_00FF, 32'h0000_0100, 3'b011);
        // Reserved op
        send($urandom, $urandom, 3'b100);
        send(32'd5, 32'd3, 3'b100);
        drain();

        // Backpressure: hold the result, pulse in_valid, then release.
        rdy_mode = 2;
        out_ready = 1'b0;
        send(32'h0000_1234, 32'h0000_1235, 3'b010);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            #1;
            got = out_valid;
        end
        check("bp_result_seen", 64'(got), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
            #2;
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_out_valid_held", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rdy_mode = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        drain();

        // Reset during RUN discards the operation.
        send(32'd5, 32'd5, 3'b001);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_run_out_valid", 64'(out_valid), 64'd0);
        check("rst_run_in_ready", 64'(in_ready), 64'd1);
        check("rst_run_S", 64'(s), 64'd0);
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        @(negedge clk);
        check("rst_hold_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b1;
        send(32'd7, 32'd9, 3'b010);
        send(32'd5, 32'd5, 3'b001);
        drain();

        // Randomised traffic with random consumer stalls.
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            ra = pick_a();
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       begin
                             rb = ra;
                             rb[8 * $urandom_range(0, 3) +: 8] = 8'($urandom);
                         end
                2:       rb = pick_a();
                default: rb = $urandom;
            endcase
            send(ra, rb, 3'($urandom_range(0, 7)));
        end
        rdy_mode = 0;
        drain();

        // Other parametrisations: 64/16 and N=1.
        run_pair(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'hFFFF_FFFF, 32'd1, 3'b010);
        run_pair(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'hFFFF_FFFF, 32'd1, 3'b011);
        run_pair(64'h0012_0000_0000_0000, 64'h0013_0000_0000_0000, 32'h1200_0000, 32'h1300_0000, 3'b000);
        for (int i = 0; i < 20; i++) begin
            w1 = {$urandom, $urandom};
            ra = $urandom;
            run_pair(w1, ($urandom_range(0, 1) != 0) ? w1 : {$urandom, $urandom},
                     ra, ($urandom_range(0, 1) != 0) ? ra : 32'($urandom),
                     3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_cmp_seq.md
# alu_cmp_seq

Parametrised, multi-cycle comparison unit for the ALU compare path. It compares two WIDTH-bit operands one SLICE-bit slice per cycle, scanning from the most significant slice down, and returns a WIDTH-bit result that is zero-extended from a 1-bit outcome. It keeps the existing 3-bit compare op encoding and adds unsigned less-than. It replaces the single-cycle flag-based compare wherever a wide datapath would make a one-cycle magnitude compare the critical path; operands enter and the result leaves through valid/ready handshakes.

## Interface
- WIDTH, 32, operand and result width in bits.
- SLICE, 8, bits compared per cycle. WIDTH must be a multiple of SLICE; any other value must fail elaboration.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  unit can accept operands; high only in IDLE.
- A  input  WIDTH  first operand, two's complement.
- B  input  WIDTH  second operand; ignored for zero-compare ops.
- op  input  3  compare select, same meaning as ALUFun[3:1].
- out_valid  output  1  S holds a completed result.
- out_ready  input  1  consumer accepts the result.
- S  output  WIDTH  result, {WIDTH-1 zeros, outcome}.

## Operation
- Op encoding:
  - 001 EQ: A==B.
  - 000 NEQ: A!=B.
  - 010 LT: signed A<B.
  - 011 LTU: unsigned A<B. This op is new.
  - 110 LEZ: signed A<=0.
  - 101 LTZ: signed A<0.
  - 111 GTZ: signed A>0.
  - 100: reserved. The scan still runs and the result is S=0.
- Effective B is the zero vector for ops 110, 101 and 111.
- Capture: on the accept edge (in_valid && in_ready), register A, effective B and op. Changes on the input ports after that edge are ignored.
- Scan: N = WIDTH/SLICE slices, indexed from the MSB slice (index N-1) down to 0.
  - Track two flags: `decided` and `lt`.
  - At the first slice where A and B differ, set `decided` and set `lt` from that slice's comparison.
  - For the top slice, the comparison is signed for LT, LEZ, LTZ and GTZ, and unsigned for LTU.
  - For every lower slice, the comparison is unsigned.
  - Once `decided` is set, later slices do not change the flags.
- Outcome once the scan ends:
  - eq = !decided.
  - EQ = eq; NEQ = !eq.
  - LT, LTU and LTZ = lt.
  - LEZ = lt | eq.
  - GTZ = !lt & !eq.
- FSM states:
  - IDLE: in_ready=1. Goes to RUN on accept.
  - RUN: processes one slice per cycle. Goes to DONE after the last slice is processed.
  - DONE: out_valid=1 and S is stable. Goes to IDLE on an edge where out_ready=1.
- Slice counter: counts N-1 down to 0 in RUN and does not wrap. Leaving RUN at count 0 is the only exit without the early-exit feature.
- in_valid is ignored in RUN and DONE. There is no queueing, and in_valid in those states does not abort the scan.
- If out_ready is held high before DONE is entered, the unit leaves DONE on the first edge in DONE, so out_valid is high for exactly one cycle.

## Timing
- Reset (asynchronous, takes effect immediately while reset=0):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, S=0.
  - The slice counter and flags clear.
  - Reset during RUN or DONE discards the operation. No result is ever presented for it.
- Latency, counting the accept edge as edge 0:
  - out_valid rises after edge N (4 cycles for WIDTH=32, SLICE=8).
  - in_ready rises on the edge where the result is consumed, so the next accept can happen one edge later.
- Throughput: at best one operation per N+2 cycles (accept, N scan edges, consume).
- S and out_valid are registered outputs. in_ready decodes the state register directly.

## Configuration
- CMP_EARLY_EXIT_EN defined: RUN goes to DONE on the edge that processes the first differing slice. Latency becomes j edges, where j (1..N) is the 1-based position of that slice counting from the MSB. Equal operands still take N edges. Results are identical to the fixed-latency build.
- CMP_EARLY_EXIT_EN undefined: latency is always N. The scan continues after `decided` is set, with the flags frozen.

## Test plan
- Reset during RUN: accept A=5, B=5, op=001, then assert reset after edge 2. Required: out_valid=0 and in_ready=1 immediately; the next operation returns a correct result.
- Signed vs unsigned: A=0xFFFFFFFF, B=0x00000001.
  - op=010 gives S=1.
  - op=011 gives S=0.
  - Both have out_valid after edge 4 without CMP_EARLY_EXIT_EN.
- Zero ops on A=0:
  - op=110 gives 1.
  - op=101 gives 0.
  - op=111 gives 0.
  - Then A=0x80000000 with op=101 gives 1, and A=0x00000100 with op=111 gives 1.
- Backpressure: out_ready=0 for 5 cycles after out_valid. S must stay stable, in_valid pulses must be ignored, and raising out_ready must give in_ready=1 after that edge.
- Early exit: A=0x12000000, B=0x13000000, op=000.
  - With CMP_EARLY_EXIT_EN: S=1 after edge 1.
  - Without it: S=1 after edge 4.
  - Equal operands take 4 edges in both builds.
- Reserved op and parametrisation: op=100 gives S=0. Rerun the signed/unsigned case with WIDTH=64, SLICE=16 and also with SLICE=WIDTH (N=1, latency 1).
